// File: rtl/lfsr_prng_gen.sv
// Pseudo-random word generator: a Fibonacci or Galois LFSR collects OUT_W shifted-out bits per word
// and hands each word over a valid/ready handshake. It also provides run control, seed loading and wrap detection.
module lfsr_prng_gen #(
  parameter int            N     = 16,
  parameter logic [N-1:0]  TAPS  = 16'h002D,
  parameter logic [N-1:0]  INIT  = 16'h0001,
  parameter bit            MODE  = 1'b0,
  parameter int            OUT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             seed_load,
  input  logic [N-1:0]     seed,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic [N-1:0]     lfsr_state,
  output logic             lockup,
  output logic             wrapped
);

  localparam int            CW   = $clog2(OUT_W) + 1;
  localparam logic [CW-1:0] LAST = CW'(OUT_W - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, VALID = 2'd2} fsm_t;

  fsm_t             fsm_r, fsm_s;
  logic             run_r, run_s;
  logic [CW-1:0]    bit_cnt_r, bit_cnt_s;
  logic [OUT_W-1:0] acc_r, acc_s;
  logic [N-1:0]     state_r, state_s, seed_q_r, seed_q_s, step_s, seed_fix_s;
  logic [OUT_W-1:0] out_data_r, out_data_s;
  logic             out_valid_r, out_valid_s, lockup_r, lockup_s, wrapped_r, wrapped_s;

  function automatic logic [N-1:0] lfsr_step(input logic [N-1:0] s);
    if (MODE == 1'b0) begin
      lfsr_step = {^(s & TAPS), s[N-1:1]};
    end else begin
      lfsr_step = {1'b0, s[N-1:1]} ^ (s[0] ? TAPS : {N{1'b0}});
    end
  endfunction

  // next-state logic for the FSM, LFSR, accumulator and status pulses
  always_comb begin
    fsm_s       = fsm_r;
    run_s       = run_r;
    bit_cnt_s   = bit_cnt_r;
    acc_s       = acc_r;
    state_s     = state_r;
    seed_q_s    = seed_q_r;
    out_data_s  = out_data_r;
    out_valid_s = out_valid_r;
    lockup_s    = 1'b0;
    wrapped_s   = 1'b0;
    step_s      = lfsr_step(state_r);
    seed_fix_s  = (seed == {N{1'b0}}) ? INIT : seed;
    if (seed_load) begin
      // a zero seed would freeze the register, so fall back to INIT and flag it
      state_s     = seed_fix_s;
      seed_q_s    = seed_fix_s;
      lockup_s    = (seed == {N{1'b0}});
      fsm_s       = IDLE;
      run_s       = 1'b0;
      out_valid_s = 1'b0;
      bit_cnt_s   = {CW{1'b0}};
      acc_s       = {OUT_W{1'b0}};
    end else begin
      if (stop) begin
        run_s = 1'b0;
      end else if (start) begin
        run_s = 1'b1;
      end else begin
        run_s = run_r;
      end
      case (fsm_r)
        IDLE: begin
          if (start && !stop) begin
            fsm_s     = FILL;
            bit_cnt_s = {CW{1'b0}};
          end else begin
            fsm_s = IDLE;
          end
        end
        FILL: begin
          state_s   = step_s;
          wrapped_s = (step_s == seed_q_r);
          for (int i = 0; i < OUT_W; i++) begin
            if (CW'(i) == bit_cnt_r) begin
              acc_s[i] = state_r[0];
            end else begin
              acc_s[i] = acc_r[i];
            end
          end
          if (bit_cnt_r == LAST) begin
            fsm_s       = VALID;
            out_data_s  = acc_s;
            out_valid_s = 1'b1;
            bit_cnt_s   = {CW{1'b0}};
          end else begin
            bit_cnt_s = bit_cnt_r + CW'(1);
          end
        end
        VALID: begin
          if (out_ready) begin
            out_valid_s = 1'b0;
            fsm_s       = run_s ? FILL : IDLE;
          end else begin
            fsm_s = VALID;
          end
        end
        default: begin
          fsm_s       = IDLE;
          run_s       = 1'b0;
          out_valid_s = 1'b0;
        end
      endcase
    end
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_r       <= IDLE;
      run_r       <= 1'b0;
      bit_cnt_r   <= {CW{1'b0}};
      acc_r       <= {OUT_W{1'b0}};
      state_r     <= INIT;
      seed_q_r    <= INIT;
      out_data_r  <= {OUT_W{1'b0}};
      out_valid_r <= 1'b0;
      lockup_r    <= 1'b0;
      wrapped_r   <= 1'b0;
    end else begin
      fsm_r       <= fsm_s;
      run_r       <= run_s;
      bit_cnt_r   <= bit_cnt_s;
      acc_r       <= acc_s;
      state_r     <= state_s;
      seed_q_r    <= seed_q_s;
      out_data_r  <= out_data_s;
      out_valid_r <= out_valid_s;
      lockup_r    <= lockup_s;
      wrapped_r   <= wrapped_s;
    end
  end

  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
  assign lfsr_state = state_r;
  assign lockup     = lockup_r;
  assign wrapped    = wrapped_r;

endmodule
